inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Fetch stage: owns the PC, issues in-order word reads to instruction memory and buffers the returned words.
//  Presents {inst_code, inst_pc} to decode (register read, imm_Gen, control) over a valid/ready handshake.
//  Accepts PC redirects from branch/JAL/JALR resolution and flushes wrong-path words.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  FIFO_DEPTH  2              prefetch entries; power of 2, >=2
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   synchronous, active-high
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   imem accepts request this cycle
//  imem_req_addr   out  32  word address (byte addr, [1:0]=0)
//  imem_rsp_valid  in   1   read data valid; responses in request order, >=1 cycle after acceptance
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   redirect PC this cycle
//  redirect_pc     in   32  redirect target
//  dec_ready       in   1   decode accepts instruction
//  inst_valid      out  1   inst_code/inst_pc valid
//  inst_code       out  32  instruction to decode/imm_Gen
//  inst_pc         out  32  PC of inst_code
//  misalign_err    out  1   sticky misaligned-target flag (0 when macro absent)
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, outstanding=0, drop=0, state=S_BOOT; imem_req_valid=0, inst_valid=0,
//   inst_code=32'h0000_0013 (NOP), inst_pc=RESET_PC, misalign_err=0. Reset mid-burst discards everything.
//  FSM: S_BOOT -> S_FETCH after one cycle (no request in S_BOOT). S_TRAP only with macro.
//  Credit: imem_req_valid = S_FETCH && !redirect_valid && (fifo_count+outstanding-drop < FIFO_DEPTH).
//  Accept (valid&&ready): pc += 4 (wraps 32'hFFFF_FFFC -> 0), outstanding++.
//  Response: outstanding--; if drop>0 then drop--, data discarded; else push {data, pc_tag}.
//   pc_tag from an in-order tag queue captured at accept (depth FIFO_DEPTH).
//  Output: head of FIFO drives inst_code/inst_pc combinationally from registered storage;
//   empty -> inst_valid=0, inst_code=NOP. Pop on inst_valid&&dec_ready.
//  Full FIFO + response: impossible by credit rule; assert in sim.
//  Latency: accept at cycle N, rsp at N+1 -> inst_valid at N+2 (FIFO write then read).
//  Redirect: FIFO and tag queue flushed, pc<=redirect_pc, drop<=outstanding (minus any response
//   consumed same cycle), no request that cycle. Redirect beats pop/push of same cycle; a same-cycle
//   dec handshake still counts as transferred (decode squashes it).
//  Back-to-back redirects: latest wins; drop recomputed each time.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 -> state S_TRAP, misalign_err=1 (sticky
//   until reset), no further requests, FIFO flushed, inst_valid=0.
//  Undefined: redirect_pc[1:0] forced to 00; misalign_err tied 0; no S_TRAP.
// STRUCTURE
//  Package riscv_fetch_pkg: NOP_INSTR=32'h0000_0013, fetch_state_t {S_BOOT,S_FETCH,S_TRAP},
//   fetch_entry_t struct {logic [31:0] code; logic [31:0] pc;}.
//  Sub-module fetch_fifo (parameter DEPTH, type fetch_entry_t; push/pop/flush/count/full/empty),
//   instantiated for data FIFO; tag queue may reuse it with pc-only payload.
// TESTING
//  Reset, imem always ready, 1-cycle rsp -> first req addr 0x0 in cycle after S_BOOT; inst_valid at
//   addr0 +2 cycles; PCs 0,4,8,... one per cycle.
//  dec_ready=0 for 10 cycles -> requests stop after FIFO_DEPTH outstanding+buffered; no word lost; order kept.
//  Redirect to 0x100 with 2 requests in flight -> 2 responses dropped; next inst_pc=0x100, code=mem[0x100].
//  Redirect and dec handshake same cycle -> handshake word delivered once, FIFO empty next cycle.
//  imem_req_ready low 5 cycles -> addr held stable, pc unchanged.
//  Macro on, redirect_pc=0x102 -> misalign_err=1 next cycle, imem_req_valid=0 thereafter until reset;
//   macro off -> fetch from 0x100.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types: state encoding, prefetch entry and the NOP word.
// S_TRAP exists only when FETCH_MISALIGN_CHECK_EN is defined.
package riscv_fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        S_TRAP
`endif
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with synchronous flush; head is read combinationally
// from registered storage.
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC owner, credit-limited in-order imem requests, prefetch FIFO to decode.
// Define FETCH_MISALIGN_CHECK_EN to trap (sticky misalign_err) on misaligned redirect targets.
module inst_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_ready,
    output logic        inst_valid,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    // Outstanding includes responses still owed for flushed requests, so repeated
    // redirects can push it past FIFO_DEPTH; the extra bits give that headroom.
    localparam int unsigned OW = CW + 4;

    fetch_state_t   state_q, state_d;
    logic [31:0]    pc_q;
    logic [OW-1:0]  outstanding_q;
    logic [OW-1:0]  drop_q;
    logic [OW-1:0]  out_after_rsp;
    logic [31:0]    redirect_tgt;
    logic           trap_active;
    logic           credit_ok;
    logic           accept;
    logic           rsp_live;
    logic           flush;

    fetch_entry_t   data_in, data_head;
    logic [CW-1:0]  data_count;
    logic           data_full, data_empty, data_pop;
    logic [31:0]    tag_head;
    logic [CW-1:0]  tag_count;
    logic           tag_full, tag_empty;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic redirect_bad;
    logic misalign_q;

    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc;
    assign trap_active  = (state_q == S_TRAP);
    assign misalign_err = misalign_q;
`else
    assign redirect_tgt = redirect_pc & ~32'h3;
    assign trap_active  = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign accept        = imem_req_valid && imem_req_ready;
    assign rsp_live      = imem_rsp_valid && (drop_q == '0);
    assign out_after_rsp = outstanding_q - OW'(imem_rsp_valid);
    assign credit_ok     = (OW'(data_count) + outstanding_q - drop_q) < OW'(FIFO_DEPTH);
    assign flush         = redirect_valid || trap_active;
    assign imem_req_addr = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        imem_req_valid = 1'b0;
        unique case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: imem_req_valid = !redirect_valid && credit_ok;
`ifdef FETCH_MISALIGN_CHECK_EN
            S_TRAP:  state_d = S_TRAP;
`endif
            default: state_d = S_BOOT;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_valid && redirect_bad) begin
            state_d = S_TRAP;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            outstanding_q <= out_after_rsp + OW'(accept);
            if (redirect_valid) begin
                // Everything still owed after this cycle's response belongs to the old path.
                drop_q <= out_after_rsp;
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect_bad) begin
                    misalign_q <= 1'b1;
                end else begin
                    pc_q <= redirect_tgt;
                end
`else
                pc_q <= redirect_tgt;
`endif
            end else begin
                if (imem_rsp_valid && (drop_q != '0)) begin
                    drop_q <= drop_q - 1'b1;
                end
                if (accept) begin
                    pc_q <= pc_q + 32'd4;
                end
            end
        end
    end

    assign data_in  = '{code: imem_rsp_data, pc: tag_head};
    assign data_pop = inst_valid && dec_ready;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_data_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_live),
        .push_data (data_in),
        .pop       (data_pop),
        .flush     (flush),
        .head      (data_head),
        .count     (data_count),
        .full      (data_full),
        .empty     (data_empty)
    );

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (logic [31:0])
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (pc_q),
        .pop       (rsp_live),
        .flush     (flush),
        .head      (tag_head),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign inst_valid = !data_empty && !trap_active;
    assign inst_code  = inst_valid ? data_head.code : NOP_INSTR;
    assign inst_pc    = inst_valid ? data_head.pc   : pc_q;

    assert property (@(posedge clk) disable iff (reset) !(rsp_live && data_full && !redirect_valid));
    assert property (@(posedge clk) disable iff (reset) !(rsp_live && tag_empty));
    assert property (@(posedge clk) disable iff (reset) !(accept && tag_full));
    assert property (@(posedge clk) disable iff (reset) OW'(tag_count) == (outstanding_q - drop_q));

endmodule
